// File: rtl/mem_cache_controller_pkg.sv
// mem_cache_controller_pkg: FSM encoding, request-enable constants and address-field width helpers.
package mem_cache_controller_pkg;
    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;
    localparam logic ENABLE = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam int WORD_BITS = 2;
    function automatic int tag_bits(input int cached_bits, input int index_bits);
        return cached_bits - index_bits - WORD_BITS;
    endfunction
endpackage

// File: rtl/cache_line_array.sv
// cache_line_array: direct-mapped valid/tag/data store, async read port, sync write port, active-low clear.
module cache_line_array #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS = 10,
    parameter int DATA_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [INDEX_BITS-1:0] i_widx,
    input  logic [TAG_BITS-1:0]   i_wtag,
    input  logic [DATA_LEN-1:0]   i_wdata,
    input  logic [INDEX_BITS-1:0] i_ridx,
    output logic                  o_valid,
    output logic [TAG_BITS-1:0]   o_tag,
    output logic [DATA_LEN-1:0]   o_data
);
    logic [2**INDEX_BITS-1:0] r_valid;
    logic [TAG_BITS-1:0]      r_tag  [2**INDEX_BITS];
    logic [DATA_LEN-1:0]      r_data [2**INDEX_BITS];

    // only valid bits need clearing; stale tag/data are masked by valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_valid <= '0;
        else if (i_we) r_valid[i_widx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_widx]  <= i_wtag;
            r_data[i_widx] <= i_wdata;
        end
    end

    assign o_valid = r_valid[i_ridx];
    assign o_tag   = r_tag[i_ridx];
    assign o_data  = r_data[i_ridx];
endmodule

// File: rtl/mem_cache_controller.sv
// mem_cache_controller: direct-mapped write-through no-write-allocate word cache in front of the SRAM controller.
// Define CACHE_STATS_EN to add hit_count/miss_count outputs.
module mem_cache_controller
    import mem_cache_controller_pkg::*;
#(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32,
    parameter int INDEX_BITS = 6,
    parameter int CACHED_ADDR_BITS = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read_enable,
    input  logic                write_enable,
    input  logic [ADDR_LEN-1:0] address,
    input  logic [DATA_LEN-1:0] write_data,
    output logic [DATA_LEN-1:0] read_data,
    output logic                ready,
    output logic                sram_read_enable,
    output logic                sram_write_enable,
    output logic [ADDR_LEN-1:0] sram_address,
    output logic [DATA_LEN-1:0] sram_write_data,
    input  logic [DATA_LEN-1:0] sram_read_data,
    input  logic                sram_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
`endif
);
    localparam int TAG_BITS = tag_bits(CACHED_ADDR_BITS, INDEX_BITS);
    localparam int TAG_LSB = INDEX_BITS + WORD_BITS;

    state_t                r_state, w_next;
    logic [ADDR_LEN-1:0]   r_addr;
    logic [DATA_LEN-1:0]   r_wdata;
    logic                  r_wr_hit, r_wr_done;
    logic                  w_idle, w_hit, w_rd_hit, w_wr_req, w_fill, w_we;
    logic                  w_line_valid;
    logic [TAG_BITS-1:0]   w_line_tag;
    logic [DATA_LEN-1:0]   w_line_data;
    logic                  w_unused;

    cache_line_array #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS(TAG_BITS),
        .DATA_LEN(DATA_LEN)
    ) u_lines (
        .clk(clk),
        .rst_n(rst),
        .i_we(w_we),
        .i_widx(r_addr[TAG_LSB-1:WORD_BITS]),
        .i_wtag(r_addr[CACHED_ADDR_BITS-1:TAG_LSB]),
        .i_wdata(w_fill ? sram_read_data : r_wdata),
        .i_ridx(address[TAG_LSB-1:WORD_BITS]),
        .o_valid(w_line_valid),
        .o_tag(w_line_tag),
        .o_data(w_line_data)
    );

    assign w_unused = ^{address[ADDR_LEN-1:CACHED_ADDR_BITS], address[WORD_BITS-1:0]};
    assign w_idle   = r_state == IDLE;
    assign w_hit    = w_line_valid && (w_line_tag == address[CACHED_ADDR_BITS-1:TAG_LSB]);
    assign w_rd_hit = w_idle && read_enable && w_hit;
    // a write still held high in the cycle after completion is the finished one, not a new store
    assign w_wr_req = write_enable && !r_wr_done;
    assign w_fill   = (r_state == RD_WAIT) && sram_ready;
    assign w_we     = w_fill || ((r_state == WR_WAIT) && sram_ready && r_wr_hit);

    assign ready             = w_idle && (read_enable ? w_hit : !w_wr_req);
    assign read_data         = w_rd_hit ? w_line_data : '0;
    assign sram_read_enable  = (r_state == RD_REQ || r_state == RD_WAIT) ? ENABLE : DISABLE;
    assign sram_write_enable = (r_state == WR_REQ || r_state == WR_WAIT) ? ENABLE : DISABLE;
    assign sram_address      = r_addr;
    assign sram_write_data   = r_wdata;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = read_enable ? (w_hit ? IDLE : RD_REQ) : (w_wr_req ? WR_REQ : IDLE);
            RD_REQ:  w_next = sram_ready ? RD_REQ : RD_WAIT;
            RD_WAIT: w_next = sram_ready ? IDLE : RD_WAIT;
            WR_REQ:  w_next = sram_ready ? WR_REQ : WR_WAIT;
            WR_WAIT: w_next = sram_ready ? IDLE : WR_WAIT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wr_hit  <= 1'b0;
            r_wr_done <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_wr_done <= (r_state == WR_WAIT) && sram_ready;
            if (w_idle && (read_enable ? !w_hit : w_wr_req)) r_addr <= address;
            if (w_idle && !read_enable && w_wr_req) begin
                r_wdata  <= write_data;
                r_wr_hit <= w_hit;
            end
        end
    end

`ifdef CACHE_STATS_EN
    logic        r_post_fill;
    logic [31:0] r_hit_count, r_miss_count;

    // the hit seen right after a fill belongs to the miss already counted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_post_fill  <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_post_fill <= w_fill;
            if (w_rd_hit && !r_post_fill) r_hit_count <= r_hit_count + 32'd1;
            if (w_idle && w_next == RD_REQ) r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif
endmodule

// File: tb/tb_mem_cache_controller.sv
// tb_mem_cache_controller: directed self-checking bench with a fixed-latency SRAM controller model.
// Define CACHE_STATS_EN to also exercise the hit/miss counters.
module tb_mem_cache_controller;
    localparam int LAT = 3;
    localparam int MISS_CYC = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        read_enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic        sram_read_enable;
    logic        sram_write_enable;
    logic [31:0] sram_address;
    logic [31:0] sram_write_data;
    logic [31:0] sram_read_data;
    logic        sram_ready;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_checks = 0;
    int n_fail = 0;
    int wr_count = 0;
    logic [31:0] mem [4096];
    int m_state;
    int m_cnt;
    logic [11:0] m_addr;

    always #5 clk = ~clk;

    mem_cache_controller dut (
        .clk(clk),
        .rst(rst),
        .read_enable(read_enable),
        .write_enable(write_enable),
        .address(address),
        .write_data(write_data),
        .read_data(read_data),
        .ready(ready),
        .sram_read_enable(sram_read_enable),
        .sram_write_enable(sram_write_enable),
        .sram_address(sram_address),
        .sram_write_data(sram_write_data),
        .sram_read_data(sram_read_data),
        .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    // SRAM controller model: accepts a request when idle, busy LAT cycles, ready for one cycle, then idle
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_ready <= 1'b1;
            sram_read_data <= '0;
            m_state <= 0;
            m_cnt <= 0;
        end else begin
            case (m_state)
                0: if (sram_read_enable || sram_write_enable) begin
                    m_state <= 1;
                    m_cnt <= LAT;
                    sram_ready <= 1'b0;
                    m_addr <= sram_address[13:2];
                    if (sram_write_enable && !sram_read_enable) begin
                        mem[sram_address[13:2]] = sram_write_data;
                        wr_count = wr_count + 1;
                    end
                end
                1: if (m_cnt == 1) begin
                    sram_ready <= 1'b1;
                    sram_read_data <= mem[m_addr];
                    m_state <= 2;
                end else m_cnt <= m_cnt - 1;
                default: m_state <= 0;
            endcase
        end
    end

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input bit miss, input bit also_wr, input string nm);
        int cyc;
        bit re_seen;
        @(negedge clk);
        address = a;
        read_enable = 1'b1;
        write_enable = also_wr;
        #1;
        n_checks++;
        if (ready !== !miss) begin n_fail++; $display("FAIL %s first-cycle ready got %b want %b", nm, ready, !miss); end
        cyc = 0;
        re_seen = sram_read_enable;
        while (ready !== 1'b1 && cyc < 50) begin
            @(negedge clk); #1;
            cyc++;
            re_seen |= sram_read_enable;
        end
        n_checks++;
        if (cyc != (miss ? MISS_CYC : 0)) begin n_fail++; $display("FAIL %s latency got %0d want %0d", nm, cyc, miss ? MISS_CYC : 0); end
        n_checks++;
        if (read_data !== exp) begin n_fail++; $display("FAIL %s read_data got %h want %h", nm, read_data, exp); end
        n_checks++;
        if (re_seen !== miss) begin n_fail++; $display("FAIL %s sram_read_enable seen %b want %b", nm, re_seen, miss); end
        @(negedge clk);
        read_enable = 1'b0;
        write_enable = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input string nm);
        int cyc;
        int wc0;
        bit we_seen;
        wc0 = wr_count;
        @(negedge clk);
        address = a;
        write_data = d;
        write_enable = 1'b1;
        #1;
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL %s first-cycle ready got %b want 0", nm, ready); end
        cyc = 0;
        we_seen = 1'b0;
        while (ready !== 1'b1 && cyc < 50) begin
            @(negedge clk); #1;
            cyc++;
            we_seen |= sram_write_enable;
        end
        n_checks++;
        if (cyc != MISS_CYC) begin n_fail++; $display("FAIL %s latency got %0d want %0d", nm, cyc, MISS_CYC); end
        n_checks++;
        if (we_seen !== 1'b1) begin n_fail++; $display("FAIL %s sram_write_enable never seen", nm); end
        n_checks++;
        if (mem[a[13:2]] !== d || wr_count != wc0 + 1) begin
            n_fail++; $display("FAIL %s sram word got %h (writes %0d) want %h (writes %0d)", nm, mem[a[13:2]], wr_count - wc0, d, 1);
        end
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL reset ready got %b want 1", ready); end
        n_checks++;
        if (read_data !== 32'h0) begin n_fail++; $display("FAIL reset read_data got %h want 0", read_data); end
        n_checks++;
        if ({sram_read_enable, sram_write_enable} !== 2'b00) begin
            n_fail++; $display("FAIL reset sram enables got %b%b want 00", sram_read_enable, sram_write_enable);
        end
        n_checks++;
        if (sram_address !== 32'h0 || sram_write_data !== 32'h0) begin
            n_fail++; $display("FAIL reset sram addr/data got %h/%h want 0/0", sram_address, sram_write_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_read_fill();
        do_read(32'h0000_0040, 32'hDEADBEEF, 1'b1, 1'b0, "read_miss_0x40");
        do_read(32'h0000_0040, 32'hDEADBEEF, 1'b0, 1'b0, "read_hit_0x40");
    endtask

    task automatic test_write_hit();
        do_write(32'h0000_0040, 32'h12345678, "write_hit_0x40");
        do_read(32'h0000_0040, 32'h12345678, 1'b0, 1'b0, "read_after_write_hit");
    endtask

    task automatic test_write_miss();
        do_write(32'h0000_1040, 32'hA5A5A5A5, "write_miss_0x1040");
        do_read(32'h0000_0040, 32'h12345678, 1'b0, 1'b0, "line_kept_0x40");
        do_read(32'h0000_1040, 32'hA5A5A5A5, 1'b1, 1'b0, "read_miss_0x1040");
    endtask

    task automatic test_alias_and_wrap();
        do_read(32'h8000_1040, 32'hA5A5A5A5, 1'b0, 1'b0, "alias_upper_bits");
        do_read(32'h0000_00FC, 32'hC0FFEE00, 1'b1, 1'b0, "top_index_miss");
        do_read(32'h0000_00FC, 32'hC0FFEE00, 1'b0, 1'b0, "top_index_hit");
    endtask

    task automatic test_rw_collision();
        int wc0;
        wc0 = wr_count;
        write_data = 32'hFFFF_0000;
        do_read(32'h0000_0080, 32'h0BADF00D, 1'b1, 1'b1, "rw_both_read");
        n_checks++;
        if (wr_count != wc0 || mem[32] !== 32'h0BADF00D) begin
            n_fail++; $display("FAIL rw_both_no_write writes %0d word %h want 0 writes word 0badf00d", wr_count - wc0, mem[32]);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        address = 32'h0000_00C0;
        read_enable = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (sram_read_enable !== 1'b1 || sram_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_fill_inflight re=%b sram_ready=%b want 1/0", sram_read_enable, sram_ready);
        end
        read_enable = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (sram_read_enable !== 1'b0 || ready !== 1'b1 || sram_address !== 32'h0 || read_data !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_outputs re=%b ready=%b addr=%h rd=%h want 0/1/0/0", sram_read_enable, ready, sram_address, read_data);
        end
        @(negedge clk);
        rst = 1'b1;
        do_read(32'h0000_1040, 32'hA5A5A5A5, 1'b1, 1'b0, "invalidated_after_reset");
    endtask

`ifdef CACHE_STATS_EN
    task automatic test_stats();
        do_read(32'h0000_00FC, 32'hC0FFEE00, 1'b1, 1'b0, "stats_miss_fc");
        do_read(32'h0000_0080, 32'h0BADF00D, 1'b1, 1'b0, "stats_miss_80");
        do_read(32'h0000_1040, 32'hA5A5A5A5, 1'b0, 1'b0, "stats_hit_1");
        do_read(32'h0000_00FC, 32'hC0FFEE00, 1'b0, 1'b0, "stats_hit_2");
        do_read(32'h0000_0080, 32'h0BADF00D, 1'b0, 1'b0, "stats_hit_3");
        do_read(32'h0000_1040, 32'hA5A5A5A5, 1'b0, 1'b0, "stats_hit_4");
        do_read(32'h0000_00FC, 32'hC0FFEE00, 1'b0, 1'b0, "stats_hit_5");
        n_checks++;
        if (miss_count !== 32'd3 || hit_count !== 32'd5) begin
            n_fail++; $display("FAIL stats_counts miss=%0d hit=%0d want 3/5", miss_count, hit_count);
        end
        @(negedge clk);
        force dut.r_hit_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_hit_count;
        do_read(32'h0000_0080, 32'h0BADF00D, 1'b0, 1'b0, "stats_wrap_hit");
        n_checks++;
        if (hit_count !== 32'h0 || miss_count !== 32'd3) begin
            n_fail++; $display("FAIL stats_wrap hit=%h miss=%0d want 0/3", hit_count, miss_count);
        end
    endtask
`endif

    initial begin
        mem[16] = 32'hDEADBEEF;
        mem[32] = 32'h0BADF00D;
        mem[48] = 32'h0C0C0C0C;
        mem[63] = 32'hC0FFEE00;
        mem[1040] = 32'h0;
        test_reset();
        test_read_fill();
        test_write_hit();
        test_write_miss();
        test_alias_and_wrap();
        test_rw_collision();
        test_reset_mid();
`ifdef CACHE_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_cache_controller.md
Name: mem_cache_controller

Overview:
- Direct-mapped, write-through, no-write-allocate word cache between the Memory stage and the SRAM controller.
- Read hits return data in the same cycle with ready held high. Misses and all writes go to the SRAM controller; ready stays low until that transaction completes, freezing the pipeline.
- To the Memory stage it presents the same enable/address/data/ready interface the SRAM controller exposes.

Parameters:
- ADDR_LEN, 32, Memory-stage byte-address width.
- DATA_LEN, 32, word width.
- INDEX_BITS, 6, line-index bits; 2**INDEX_BITS one-word lines.
- CACHED_ADDR_BITS, 18, low byte-address bits that are significant to SRAM. Tag = address[CACHED_ADDR_BITS-1 : INDEX_BITS+2].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- read_enable  in  1  Memory-stage load request (level).
- write_enable  in  1  Memory-stage store request (level).
- address  in  ADDR_LEN  byte address, word aligned; bits [1:0] are ignored.
- write_data  in  DATA_LEN  store data.
- read_data  out  DATA_LEN  load data; valid when ready=1 and read_enable=1.
- ready  out  1  0 = freeze the pipeline.
- sram_read_enable  out  1  request to the SRAM controller.
- sram_write_enable  out  1  request to the SRAM controller.
- sram_address  out  ADDR_LEN  registered copy of address.
- sram_write_data  out  DATA_LEN  registered copy of write_data.
- sram_read_data  in  DATA_LEN  fill data from the SRAM controller.
- sram_ready  in  1  SRAM controller ready; low while busy.

Behaviour:
- Storage, per line: valid (1 bit), tag, data word.
- Reset (rst=0, asynchronous):
  - All valid bits = 0; FSM = IDLE.
  - sram_read_enable = sram_write_enable = 0.
  - sram_address = 0, sram_write_data = 0.
  - ready = 1 (combinational in IDLE with no request); read_data = 0 while not driving a hit.
- Hit = valid[idx] && tag[idx] == address tag.
- Request precedence: if read_enable and write_enable are both 1, the read is served and the write is ignored (same as the SRAM controller).
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- IDLE:
  - No request: ready = 1.
  - Read hit: ready = 1 and read_data = line data combinationally, 0-cycle latency; state unchanged.
  - Read miss: ready = 0; latch address; go to RD_REQ.
  - Write (hit or miss): ready = 0; latch address and write_data; go to WR_REQ.
- RD_REQ / WR_REQ:
  - sram_*_enable = 1, decoded from the state.
  - Advance to *_WAIT on the first edge where sram_ready=0 (controller accepted).
- RD_WAIT:
  - Enable stays 1.
  - On the edge where sram_ready=1:
    - Write the line: valid=1, tag, data = sram_read_data.
    - Go to IDLE.
  - The enable drops in the same registered transition, so the controller's next IDLE cycle sees no request.
- WR_WAIT:
  - On sram_ready=1, if the latched address hits the line (pre-check registered at entry), the line data takes the latched write_data.
  - A miss leaves the line untouched (no allocate). Go to IDLE.
- Completion:
  - Back in IDLE, a read re-evaluates and now hits, so ready=1 with the fill data.
  - Read miss latency is therefore fill time + 1 cycle.
  - A write's ready rises once in IDLE; the Memory stage deasserts write_enable on advancing.
- ready is always 0 outside IDLE.
- Address or data changes while ready=0 are ignored; latched copies are used.
- Index wrap: the highest index behaves identically to the others. Addresses differing only above CACHED_ADDR_BITS alias to the same tag.
- Reset mid-transaction: FSM returns to IDLE and lines are invalidated; the SRAM controller shares the reset tree. No partial fill is committed.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments once per IDLE cycle with a read hit that is not a post-fill re-evaluation.
  - miss_count increments on the IDLE→RD_REQ transition.
  - Both counters wrap at 2**32.
- Undefined: the ports and counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: FSM state encoding, tag/index width derivations, and ENABLE/DISABLE constants beside the existing defines.
- One sub-module, cache_line_array:
  - valid/tag/data storage.
  - Asynchronous read port (index → valid, tag, data).
  - Synchronous write port (we, index, tag, data).
  - Active-low clear.

Test Plan:
- After reset, read 0x0000_0040 with an SRAM model holding 0xDEADBEEF → ready=0 until the fill, then ready=1 with read_data=0xDEADBEEF. An immediate second read of 0x40 returns the same data with ready=1 in the same cycle and no sram_read_enable.
- Write 0x40 ← 0x12345678 (hit) → sram_write_enable pulses through completion and ready=0 until done. A following read of 0x40 hits and returns 0x12345678.
- Write 0x0000_1040 (same index, different tag) ← 0xA5A5A5A5 → SRAM written, line unchanged. Read 0x40 still hits with 0x12345678; read 0x1040 misses and fills 0xA5A5A5A5.
- Assert read_enable and write_enable together on a 0x80 miss → only sram_read_enable rises and no SRAM write occurs.
- Pull rst low during RD_WAIT → outputs return to reset values immediately. Read 0x40 afterwards → miss; the line was invalidated.
- With CACHE_STATS_EN, run 3 misses and 5 hits → miss_count=3 and hit_count=5. Preload the counter to 0xFFFFFFFF → the next hit makes it 0.
